// File: rtl/ram_banked_sync.sv
// ram_banked_sync
//   Simple-dual-port (1R1W) scratch memory of 2**ADDR_W words of DATA_W bits,
//   split into BANKS equal banks selected by the top address bits. A hardware
//   sweep zeroes every location after each reset. Requests are ignored until
//   the sweep is done.
//
//   Ports
//     clk         rising-edge clock for all logic
//     rst         synchronous reset, active high
//     wr_en       write request
//     wr_addr     write address (top BSEL_W bits pick the bank)
//     wr_data     write data
//     wr_be       byte enables, bit i covers wr_data[8i+7:8i]
//     rd_en       read request
//     rd_addr     read address (bank split as for wr_addr)
//     rd_data     registered read data, holds while rd_valid is low
//     rd_valid    rd_data carries the result of an accepted read
//     rd_wr_coll  the read returned by rd_valid hit a same-cycle write address
//     init_busy   reset or init sweep in progress; requests are dropped
//
//   Read timing: a read is sampled on the edge that ends the cycle in which
//   rd_en is high, the owning bank registers the word on that edge, and the
//   output mux registers it one edge later, so rd_valid rises two cycles after
//   the cycle that carried rd_en. Same-address read/write returns the old word.
module ram_banked_sync #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int BANKS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_wr_coll,
  output logic                init_busy
);

  localparam int BSEL_W  = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int BADDR_W = ADDR_W - BSEL_W;
  localparam int BE_W    = DATA_W / 8;
  localparam int BDEPTH  = 1 << BADDR_W;
  // Internal vector widths never drop to zero, even at the parameter extremes.
  localparam int BI_W    = (BSEL_W > 0) ? BSEL_W : 1;
  localparam int LA_W    = (BADDR_W > 0) ? BADDR_W : 1;
  localparam logic [LA_W-1:0] INIT_LAST = LA_W'(BDEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [LA_W-1:0]   init_cnt_q;

  // ---------------------------------------------------------------------------
  // Init / run controller. The sweep writes one bank-local address per cycle
  // in every bank at once, so it lasts exactly BDEPTH cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_LAST) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          // ST_RUN is only left through rst.
        end
      endcase
    end
  end

  logic init_active;
  logic wr_acc;
  logic rd_acc;
  logic collision;

  assign init_active = (state_q == ST_INIT);
  // rst is folded in so the flag is already high in the cycle rst is asserted.
  assign init_busy   = rst | init_active;
  assign wr_acc      = wr_en & ~init_busy;
  assign rd_acc      = rd_en & ~init_busy;
  assign collision   = rd_acc & wr_acc & (rd_addr == wr_addr);

  // ---------------------------------------------------------------------------
  // Address split into bank index and bank-local address.
  // ---------------------------------------------------------------------------
  logic [BI_W-1:0] wr_bank;
  logic [BI_W-1:0] rd_bank;
  logic [LA_W-1:0] wr_local;
  logic [LA_W-1:0] rd_local;

  generate
    if (BSEL_W > 0) begin : g_bsel
      assign wr_bank = wr_addr[ADDR_W-1 -: BSEL_W];
      assign rd_bank = rd_addr[ADDR_W-1 -: BSEL_W];
    end else begin : g_no_bsel
      assign wr_bank = '0;
      assign rd_bank = '0;
    end

    if (BADDR_W > 0) begin : g_local
      assign wr_local = wr_addr[BADDR_W-1:0];
      assign rd_local = rd_addr[BADDR_W-1:0];
    end else begin : g_no_local
      assign wr_local = '0;
      assign rd_local = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Shared bank write port: the init sweep and client writes never overlap,
  // so one port per bank serves both.
  // ---------------------------------------------------------------------------
  logic [LA_W-1:0]   bank_wa;
  logic [DATA_W-1:0] bank_wd;
  logic [BE_W-1:0]   bank_be;

  assign bank_wa = init_active ? init_cnt_q : wr_local;
  assign bank_wd = init_active ? '0 : wr_data;
  assign bank_be = init_active ? '1 : wr_be;

  logic [DATA_W-1:0] bank_rdata [BANKS];

  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
      logic [DATA_W-1:0] mem_q [BDEPTH];
      logic [DATA_W-1:0] rdata_q;
      logic              bank_we;
      logic              bank_re;

      assign bank_we = init_active | (wr_acc & (wr_bank == BI_W'(gi)));
      assign bank_re = rd_acc & (rd_bank == BI_W'(gi));

      // Read and write in the same always_ff: the read sees the pre-edge
      // contents, which gives read-first behaviour on a same-address clash.
      always_ff @(posedge clk) begin
        if (bank_we) begin
          for (int b = 0; b < BE_W; b++) begin
            if (bank_be[b]) begin
              mem_q[bank_wa][8*b +: 8] <= bank_wd[8*b +: 8];
            end
          end
        end
        if (bank_re) begin
          rdata_q <= mem_q[rd_local];
        end
      end

      assign bank_rdata[gi] = rdata_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read pipeline: stage 1 tracks which bank holds the word, stage 2 is the
  // registered output mux.
  // ---------------------------------------------------------------------------
  logic              rd_p1_q;
  logic              coll_p1_q;
  logic [BI_W-1:0]   bank_p1_q;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_q;
  logic              rd_coll_q;

  generate
    if (BANKS == 1) begin : g_mux_single
      assign rd_mux = bank_rdata[0];
    end else begin : g_mux_multi
      assign rd_mux = bank_rdata[bank_p1_q];
    end
  endgenerate

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_p1_q) begin
      rd_data_d = rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_p1_q    <= 1'b0;
      coll_p1_q  <= 1'b0;
      bank_p1_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_coll_q  <= 1'b0;
    end else begin
      rd_p1_q    <= rd_acc;
      coll_p1_q  <= collision;
      bank_p1_q  <= rd_bank;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_p1_q;
      rd_coll_q  <= rd_p1_q & coll_p1_q;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_wr_coll = rd_coll_q;

endmodule
